// File: rtl/grf_wb_arbiter.sv
// Register-file write-port arbiter: pipeline W-stage writes win, MDU results wait in a 4-entry in-order FIFO.
// Define GRF_WB_FWD_EN to forward the youngest queued write data for q_a on q_data.
module grf_wb_arbiter (
    input  logic        clk,
    input  logic        reset,
    input  logic        w_valid,
    input  logic [4:0]  w_a3,
    input  logic [31:0] w_wd,
    input  logic [31:0] w_pc,
    input  logic        m_valid,
    output logic        m_ready,
    input  logic [4:0]  m_a3,
    input  logic [31:0] m_wd,
    input  logic [31:0] m_pc,
    output logic        grf_we,
    output logic [4:0]  grf_a3,
    output logic [31:0] grf_wd,
    output logic [31:0] grf_pc,
    input  logic [4:0]  q_a,
    output logic        q_pend,
    output logic [31:0] q_data,
    output logic [2:0]  fifo_cnt
);

    logic [4:0]  r_fifo_a3 [0:3];
    logic [31:0] r_fifo_wd [0:3];
    logic [31:0] r_fifo_pc [0:3];
    logic [1:0]  r_head;
    logic [1:0]  r_tail;
    logic [2:0]  r_cnt;

    logic w_wr_eff;
    logic w_pop;
    logic w_push;

    // m_ready depends only on the registered count, never on this cycle's inputs.
    assign m_ready  = (r_cnt != 3'd4);
    assign fifo_cnt = r_cnt;

    assign w_wr_eff = w_valid && (w_a3 != 5'd0);
    assign w_pop    = !w_wr_eff && (r_cnt != 3'd0);
    assign w_push   = m_valid && m_ready && (m_a3 != 5'd0);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_head <= 2'd0;
            r_tail <= 2'd0;
            r_cnt  <= 3'd0;
            grf_we <= 1'b0;
            grf_a3 <= 5'd0;
            grf_wd <= 32'd0;
            grf_pc <= 32'd0;
        end else begin
            if (w_wr_eff) begin
                grf_we <= 1'b1;
                grf_a3 <= w_a3;
                grf_wd <= w_wd;
                grf_pc <= w_pc;
            end else if (w_pop) begin
                grf_we <= 1'b1;
                grf_a3 <= r_fifo_a3[r_head];
                grf_wd <= r_fifo_wd[r_head];
                grf_pc <= r_fifo_pc[r_head];
            end else begin
                grf_we <= 1'b0;
            end
            if (w_pop) begin
                r_head <= r_head + 2'd1;
            end
            if (w_push) begin
                r_tail <= r_tail + 2'd1;
            end
            r_cnt <= r_cnt + {2'b00, w_push} - {2'b00, w_pop};
        end
    end

    // Storage needs no reset: entries are only observed through the head/count window.
    always_ff @(posedge clk) begin
        if (!reset && w_push) begin
            r_fifo_a3[r_tail] <= m_a3;
            r_fifo_wd[r_tail] <= m_wd;
            r_fifo_pc[r_tail] <= m_pc;
        end
    end

    logic [1:0] w_pend_idx;
    always_comb begin
        q_pend     = 1'b0;
        w_pend_idx = 2'd0;
        for (int k = 0; k < 4; k++) begin
            w_pend_idx = r_head + 2'(k);
            if ((3'(k) < r_cnt) && (q_a != 5'd0) && (r_fifo_a3[w_pend_idx] == q_a)) begin
                q_pend = 1'b1;
            end
        end
    end

`ifdef GRF_WB_FWD_EN
    // Walk oldest to youngest so the last match (youngest) wins.
    logic [1:0]  w_fwd_idx;
    logic [31:0] w_fwd_data;
    always_comb begin
        w_fwd_data = 32'd0;
        w_fwd_idx  = 2'd0;
        for (int k = 0; k < 4; k++) begin
            w_fwd_idx = r_head + 2'(k);
            if ((3'(k) < r_cnt) && (q_a != 5'd0) && (r_fifo_a3[w_fwd_idx] == q_a)) begin
                w_fwd_data = r_fifo_wd[w_fwd_idx];
            end
        end
    end
    assign q_data = w_fwd_data;
`else
    assign q_data = 32'd0;
`endif

endmodule

// File: tb/tb_grf_wb_arbiter.sv
// Bench for grf_wb_arbiter: queue-based reference model compared every cycle, plus directed literal checks.
module tb_grf_wb_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        w_valid;
    logic [4:0]  w_a3;
    logic [31:0] w_wd;
    logic [31:0] w_pc;
    logic        m_valid;
    logic        m_ready;
    logic [4:0]  m_a3;
    logic [31:0] m_wd;
    logic [31:0] m_pc;
    logic        grf_we;
    logic [4:0]  grf_a3;
    logic [31:0] grf_wd;
    logic [31:0] grf_pc;
    logic [4:0]  q_a;
    logic        q_pend;
    logic [31:0] q_data;
    logic [2:0]  fifo_cnt;

    always #5 clk = ~clk;

    grf_wb_arbiter dut (
        .clk(clk), .reset(reset),
        .w_valid(w_valid), .w_a3(w_a3), .w_wd(w_wd), .w_pc(w_pc),
        .m_valid(m_valid), .m_ready(m_ready), .m_a3(m_a3), .m_wd(m_wd), .m_pc(m_pc),
        .grf_we(grf_we), .grf_a3(grf_a3), .grf_wd(grf_wd), .grf_pc(grf_pc),
        .q_a(q_a), .q_pend(q_pend), .q_data(q_data), .fifo_cnt(fifo_cnt)
    );

    int n_checks = 0;
    int n_errors = 0;
    bit chk_en = 1'b0;

    // Model: queued MDU entries {a3[68:64], wd[63:32], pc[31:0]}, oldest first.
    logic [68:0] exp_q[$];
    logic        exp_we = 1'b0;
    logic [4:0]  exp_a3 = '0;
    logic [31:0] exp_wd = '0;
    logic [31:0] exp_pc = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s actual=0x%0h required=0x%0h t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic wv, input logic [4:0] wa, input logic [31:0] wd,
                         input logic mv, input logic [4:0] ma, input logic [31:0] md);
        w_valid = wv; w_a3 = wa; w_wd = wd; w_pc = wd + 32'h1000;
        m_valid = mv; m_a3 = ma; m_wd = md; m_pc = md + 32'h3000;
    endtask

    // One clock: decide from the inputs what the edge must do, then apply it to the model.
    task automatic step();
        bit          rst_s, eff, do_pop, do_push;
        logic [68:0] push_e;
        logic [68:0] head_e;
        rst_s   = reset;
        eff     = w_valid && (w_a3 != 0);
        do_pop  = !eff && (exp_q.size() != 0);
        do_push = m_valid && (exp_q.size() != 4) && (m_a3 != 0);
        push_e  = {m_a3, m_wd, m_pc};
        head_e  = {w_a3, w_wd, w_pc};
        @(posedge clk);
        if (rst_s) begin
            exp_q.delete();
            exp_we = 0; exp_a3 = 0; exp_wd = 0; exp_pc = 0;
        end else begin
            if (do_pop) head_e = exp_q.pop_front();
            if (eff || do_pop) begin
                exp_we = 1;
                exp_a3 = head_e[68:64]; exp_wd = head_e[63:32]; exp_pc = head_e[31:0];
            end else begin
                exp_we = 0;
            end
            if (do_push) exp_q.push_back(push_e);
        end
        #1;
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            logic        p;
            logic [31:0] d;
            p = 0; d = 0;
            for (int i = 0; i < exp_q.size(); i++) begin
                if (q_a != 0 && exp_q[i][68:64] == q_a) begin
                    p = 1; d = exp_q[i][63:32];
                end
            end
`ifndef GRF_WB_FWD_EN
            d = 0;
`endif
            check("cyc_fifo_cnt", 32'(fifo_cnt), 32'(exp_q.size()));
            check("cyc_m_ready", 32'(m_ready), 32'(exp_q.size() != 4));
            check("cyc_grf_we", 32'(grf_we), 32'(exp_we));
            check("cyc_grf_a3", 32'(grf_a3), 32'(exp_a3));
            check("cyc_grf_wd", grf_wd, exp_wd);
            check("cyc_grf_pc", grf_pc, exp_pc);
            check("cyc_q_pend", 32'(q_pend), 32'(p));
            check("cyc_q_data", q_data, d);
        end
    end

    initial begin
        reset = 1'b1; q_a = 0;
        drive(0, 0, 0, 0, 0, 0);
        step(); step();
        reset = 1'b0;
        chk_en = 1'b1;
        check("rst_we", 32'(grf_we), 0);
        check("rst_cnt", 32'(fifo_cnt), 0);
        check("rst_ready", 32'(m_ready), 1);
        check("rst_a3", 32'(grf_a3), 0);

        // Single MDU write: queued one cycle, then issued.
        drive(0, 0, 0, 1, 5, 32'h1234);
        step();
        check("one_cnt", 32'(fifo_cnt), 1);
        check("one_we0", 32'(grf_we), 0);
        drive(0, 0, 0, 0, 0, 0);
        step();
        check("one_we", 32'(grf_we), 1);
        check("one_a3", 32'(grf_a3), 5);
        check("one_wd", grf_wd, 32'h1234);
        check("one_pc", grf_pc, 32'h4234);
        check("one_cnt0", 32'(fifo_cnt), 0);

        // Pipeline holds the port while four MDU entries fill the FIFO.
        for (int i = 0; i < 4; i++) begin
            drive(1, 1, 32'h111, 1, 5'(10 + i), 32'hA0 + 32'(i));
            step();
            check("fill_a3", 32'(grf_a3), 1);
        end
        check("full_cnt", 32'(fifo_cnt), 4);
        check("full_ready", 32'(m_ready), 0);
        // Full: a pop this cycle does not open m_ready, so a3=20 is refused.
        drive(0, 0, 0, 1, 20, 32'hEE);
        step();
        check("drain0_a3", 32'(grf_a3), 10);
        check("drain0_cnt", 32'(fifo_cnt), 3);
        drive(0, 0, 0, 0, 0, 0);
        for (int i = 1; i < 4; i++) begin
            step();
            check("drain_a3", 32'(grf_a3), 32'(10 + i));
            check("drain_wd", grf_wd, 32'hA0 + 32'(i));
        end
        check("drain_cnt", 32'(fifo_cnt), 0);

        // Two queued, then push+pop each cycle across the pointer wrap.
        drive(1, 2, 32'h222, 1, 21, 32'h21); step();
        drive(1, 2, 32'h222, 1, 22, 32'h22); step();
        for (int i = 0; i < 3; i++) begin
            drive(0, 0, 0, 1, 5'(23 + i), 32'(23 + i));
            step();
            check("wrap_cnt", 32'(fifo_cnt), 2);
            check("wrap_a3", 32'(grf_a3), 32'(21 + i));
        end
        drive(0, 0, 0, 0, 0, 0);
        step(); check("wrap_tail0", 32'(grf_a3), 24);
        step(); check("wrap_tail1", 32'(grf_a3), 25);

        // Writes to r0 on both sides are dropped; the queued head takes the port.
        drive(1, 3, 32'h333, 1, 9, 32'h99); step();
        drive(1, 0, 32'h444, 1, 0, 32'h55); step();
        check("zero_we", 32'(grf_we), 1);
        check("zero_a3", 32'(grf_a3), 9);
        check("zero_cnt", 32'(fifo_cnt), 0);
        step();
        check("zero_idle_we", 32'(grf_we), 0);
        check("zero_idle_cnt", 32'(fifo_cnt), 0);

        // Two writes to r7 queued: pending, youngest data forwarded.
        drive(1, 4, 32'h444, 1, 7, 32'hA); step();
        drive(1, 4, 32'h444, 1, 7, 32'hB); step();
        q_a = 7; #1;
        check("fwd_pend", 32'(q_pend), 1);
`ifdef GRF_WB_FWD_EN
        check("fwd_data", q_data, 32'hB);
`else
        check("fwd_data", q_data, 0);
`endif
        q_a = 0; #1;
        check("fwd_pend_r0", 32'(q_pend), 0);
        q_a = 7;

        // Reset with three entries queued and requests on both sides.
        drive(1, 4, 32'h444, 1, 6, 32'h6); step();
        check("pre_rst_cnt", 32'(fifo_cnt), 3);
        reset = 1'b1;
        drive(1, 8, 32'h888, 1, 8, 32'h8);
        step();
        reset = 1'b0;
        drive(0, 0, 0, 0, 0, 0);
        #1;
        check("mid_rst_cnt", 32'(fifo_cnt), 0);
        check("mid_rst_we", 32'(grf_we), 0);
        check("mid_rst_a3", 32'(grf_a3), 0);
        check("mid_rst_pend", 32'(q_pend), 0);
        check("mid_rst_ready", 32'(m_ready), 1);

        // Mixed traffic, checked by the per-cycle model.
        for (int i = 0; i < 60; i++) begin
            drive($urandom_range(0, 2) == 0, 5'($urandom_range(0, 5)), $urandom,
                  $urandom_range(0, 1) == 1, 5'($urandom_range(0, 7)), $urandom);
            q_a = 5'($urandom_range(0, 7));
            step();
        end
        drive(0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 6; i++) step();

        @(negedge clk);
        chk_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
